ag_io_ctrl: RTL and testbench

Parametrised memory-mapped I/O controller for the Agat-class system, decoding the C0xx/C7xx soft-switch space on the CPU bus.
- Replaces the single keyboard/button latch with a KEY_DEPTH-entry key FIFO.
- Generalises the timer interrupt into a programmable tick divider with a pending flag and acknowledge.
- Keeps the tape/beep toggles and the video-mode latch.
- Sits between the CPU bus (clocked at phi_2) and the keyboard, buttons, sound and video blocks.

---
 rtl/ag_io_pkg.sv | 30 +++
 rtl/ag_key_fifo.sv | 53 +++++
 rtl/ag_io_ctrl.sv | 170 +++++++++++++++++
 tb/tb_ag_io_ctrl.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ag_io_pkg.sv
// rtl/ag_io_pkg.sv - address windows, button code table and status bit positions
package ag_io_pkg;

    localparam logic [11:0] WIN_KEY_RD  = 12'hC00;
    localparam logic [11:0] WIN_KEY_POP = 12'hC01;
    localparam logic [11:0] WIN_TAPE    = 12'hC02;
    localparam logic [11:0] WIN_BEEP    = 12'hC03;
    localparam logic [11:0] WIN_INT_EN  = 12'hC04;
    localparam logic [11:0] WIN_INT_DIS = 12'hC05;
    localparam logic [11:0] WIN_STATUS  = 12'hC06;
    localparam logic [7:0]  WIN_VMODE   = 8'hC7;

    localparam int ST_OVF  = 7;
    localparam int ST_PEND = 6;
    localparam int ST_EN   = 5;
    localparam int ST_NE   = 4;

    // Key code injected for front-panel button idx
    function automatic logic [7:0] btn_code(input int idx);
        case (idx)
            0:       return 8'h95;
            1:       return 8'h99;
            2:       return 8'h9A;
            3:       return 8'h88;
            4:       return 8'hC9;
            default: return 8'h80 + 8'(idx);
        endcase
    endfunction

endpackage

// File: rtl/ag_key_fifo.sv
// rtl/ag_key_fifo.sv - key code FIFO with same-cycle push/pop at full and empty
module ag_key_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  head,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic          do_push;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign head    = mem[rd_ptr];
    // A pop on a full FIFO frees the slot the simultaneous push needs
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Pointer and occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents are don't-care until pushed
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ag_io_ctrl.sv
// rtl/ag_io_ctrl.sv - C0xx/C7xx soft-switch decoder with key FIFO, tick interrupt and toggles
module ag_io_ctrl
    import ag_io_pkg::*;
#(
    parameter int KEY_DEPTH = 8,
    parameter int NBTN      = 5,
    parameter int TICK_DIV  = 1,
    parameter int VM_W      = 8,
    localparam int CW       = $clog2(KEY_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     ab,
    input  logic            acc,
    input  logic            read,
    output logic [7:0]      dout,
    output logic            dout_en,
    input  logic [7:0]      key_code,
    input  logic            key_stb,
    input  logic [NBTN-1:0] btns,
    input  logic            tick_in,
    output logic [VM_W-1:0] vmode,
    output logic            tape_out,
    output logic            beep,
    output logic            int_req,
    output logic            key_ovf
);

    logic hit_key_rd, hit_key_pop, hit_tape, hit_beep;
    logic hit_int_en, hit_int_dis, hit_status, hit_vmode;

    assign hit_key_rd  = acc && (ab[15:4] == WIN_KEY_RD);
    assign hit_key_pop = acc && (ab[15:4] == WIN_KEY_POP);
    assign hit_tape    = acc && (ab[15:4] == WIN_TAPE);
    assign hit_beep    = acc && (ab[15:4] == WIN_BEEP);
    assign hit_int_en  = acc && (ab[15:4] == WIN_INT_EN);
    assign hit_int_dis = acc && (ab[15:4] == WIN_INT_DIS);
    assign hit_status  = acc && (ab[15:4] == WIN_STATUS);
    assign hit_vmode   = acc && (ab[15:8] == WIN_VMODE);

    logic [7:0]      last_key;
    logic            int_en;
    logic            int_pend;
    logic [7:0]      div;
    logic            tick_hist;
    logic [NBTN-1:0] btn_hist;
    logic [NBTN-1:0] btn_pend;

    logic [7:0]      head;
    logic [CW-1:0]   count;
    logic            full;
    logic            empty;

    logic            btn_hit;
    logic [7:0]      btn_sel_code;
    logic [NBTN-1:0] btn_mask;
    logic            push_req;
    logic [7:0]      push_data;
    logic [NBTN-1:0] btn_clr;

    // Lowest-index pending button wins; scan high to low so the last hit sticks
    always_comb begin
        btn_hit      = 1'b0;
        btn_sel_code = 8'h00;
        btn_mask     = '0;
        for (int i = NBTN - 1; i >= 0; i--) begin
            if (btn_pend[i]) begin
                btn_hit      = 1'b1;
                btn_sel_code = btn_code(i);
                btn_mask     = '0;
                btn_mask[i]  = 1'b1;
            end
        end
    end

    assign push_req  = key_stb | btn_hit;
    assign push_data = key_stb ? key_code : btn_sel_code;
    // The chosen button is retired whether its code lands or is dropped
    assign btn_clr   = (!key_stb && btn_hit) ? btn_mask : '0;

    ag_key_fifo #(.DEPTH(KEY_DEPTH), .W(8)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (hit_key_pop),
        .din   (push_data),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    logic [4:0] cnt5;
    logic [3:0] cnt_sat;
    assign cnt5    = 5'(count);
    assign cnt_sat = (cnt5 > 5'd15) ? 4'hF : cnt5[3:0];

    // CPU read data mux
    always_comb begin
        dout = 8'h00;
        if (hit_key_rd)
            dout = empty ? (last_key & 8'h7F) : (head | 8'h80);
        else if (hit_status)
            dout = {key_ovf, int_pend, int_en, ~empty, cnt_sat};
    end

    assign dout_en = read & (hit_key_rd | hit_status);
    assign int_req = int_pend;

    // Key path: last popped key, overflow flag, button edge capture
    always_ff @(posedge clk) begin
        if (reset) begin
            last_key <= 8'h00;
            key_ovf  <= 1'b0;
            btn_hist <= '0;
            btn_pend <= '0;
        end else begin
            btn_hist <= btns;
            btn_pend <= (btn_pend & ~btn_clr) | (btns & ~btn_hist);
            if (hit_key_pop && !empty) last_key <= head;
            if (hit_key_pop)
                key_ovf <= 1'b0;
            else if (push_req && full)
                key_ovf <= 1'b1;
        end
    end

    // Tape/beep toggles and video-mode latch
    always_ff @(posedge clk) begin
        if (reset) begin
            tape_out <= 1'b0;
            beep     <= 1'b0;
            vmode    <= '0;
        end else begin
            if (hit_tape)  tape_out <= ~tape_out;
            if (hit_beep)  beep     <= ~beep;
            if (hit_vmode) vmode    <= ab[VM_W-1:0];
        end
    end

    logic tick_rise;
    logic div_wrap;
    assign tick_rise = tick_in & ~tick_hist;
    assign div_wrap  = tick_rise && (div == 8'(TICK_DIV - 1));

    // Tick divider and interrupt pending; disable/ack beats a coincident wrap
    always_ff @(posedge clk) begin
        if (reset) begin
            tick_hist <= 1'b0;
            div       <= 8'h00;
            int_en    <= 1'b0;
            int_pend  <= 1'b0;
        end else begin
            tick_hist <= tick_in;
            if (div_wrap)
                div <= 8'h00;
            else if (tick_rise)
                div <= div + 8'h01;
            if (hit_int_en)
                int_en <= 1'b1;
            else if (hit_int_dis)
                int_en <= 1'b0;
            if (hit_int_dis)
                int_pend <= 1'b0;
            else if (div_wrap && int_en)
                int_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ag_io_ctrl.sv
// tb/tb_ag_io_ctrl.sv - directed self-checking bench for ag_io_ctrl
module tb_ag_io_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] ab;
    logic        acc;
    logic        read;
    logic [7:0]  dout;
    logic        dout_en;
    logic [7:0]  key_code;
    logic        key_stb;
    logic [4:0]  btns;
    logic        tick_in;
    logic [7:0]  vmode;
    logic        tape_out;
    logic        beep;
    logic        int_req;
    logic        key_ovf;

    int n_tests = 0;
    int n_fail  = 0;

    ag_io_ctrl #(.KEY_DEPTH(8), .NBTN(5), .TICK_DIV(3), .VM_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .ab       (ab),
        .acc      (acc),
        .read     (read),
        .dout     (dout),
        .dout_en  (dout_en),
        .key_code (key_code),
        .key_stb  (key_stb),
        .btns     (btns),
        .tick_in  (tick_in),
        .vmode    (vmode),
        .tape_out (tape_out),
        .beep     (beep),
        .int_req  (int_req),
        .key_ovf  (key_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic access(input logic [15:0] addr, input logic rd);
        ab   = addr;
        acc  = 1'b1;
        read = rd;
        cyc();
        acc  = 1'b0;
        read = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [7:0] exp);
        ab   = addr;
        acc  = 1'b1;
        read = 1'b1;
        #1;
        check_eq(tag, dout, exp);
        check_eq({tag, "_en"}, dout_en, 1'b1);
        cyc();
        acc  = 1'b0;
        read = 1'b0;
    endtask

    task automatic push_key(input logic [7:0] code);
        key_code = code;
        key_stb  = 1'b1;
        cyc();
        key_stb  = 1'b0;
    endtask

    task automatic tick_pulse();
        tick_in = 1'b1;
        cyc();
        tick_in = 1'b0;
        cyc();
    endtask

    initial begin
        reset = 1'b1; ab = 16'h0000; acc = 1'b0; read = 1'b0;
        key_code = 8'h00; key_stb = 1'b0; btns = 5'b0; tick_in = 1'b0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();

        check_eq("rst_dout", dout, 8'h00);
        check_eq("rst_dout_en", dout_en, 1'b0);
        check_eq("rst_vmode", vmode, 8'h00);
        check_eq("rst_tape", tape_out, 1'b0);
        check_eq("rst_beep", beep, 1'b0);
        check_eq("rst_int", int_req, 1'b0);
        check_eq("rst_ovf", key_ovf, 1'b0);
        rd_chk("rst_status", 16'hC060, 8'h00);
        rd_chk("rst_key", 16'hC000, 8'h00);

        push_key(8'h41);
        push_key(8'h42);
        push_key(8'h43);
        rd_chk("fifo_head1", 16'hC000, 8'hC1);
        rd_chk("fifo_stat3", 16'hC06F, 8'h13);
        access(16'hC010, 1'b0);
        rd_chk("fifo_head2", 16'hC005, 8'hC2);
        access(16'hC01A, 1'b1);
        access(16'hC010, 1'b0);
        rd_chk("fifo_last", 16'hC000, 8'h43);
        rd_chk("fifo_stat0", 16'hC060, 8'h00);
        access(16'hC010, 1'b0);
        rd_chk("pop_empty", 16'hC000, 8'h43);

        key_stb = 1'b1;
        for (int i = 0; i < 9; i++) begin
            key_code = 8'(8'h10 + i);
            cyc();
        end
        key_stb = 1'b0;
        check_eq("ovf_set", key_ovf, 1'b1);
        rd_chk("full_status", 16'hC060, 8'h98);
        rd_chk("full_head", 16'hC000, 8'h90);
        key_code = 8'h55;
        key_stb  = 1'b1;
        ab = 16'hC010; acc = 1'b1; read = 1'b0;
        cyc();
        key_stb = 1'b0; acc = 1'b0;
        check_eq("ovf_clr", key_ovf, 1'b0);
        rd_chk("full_pp_status", 16'hC060, 8'h18);
        for (int i = 0; i < 7; i++) begin
            rd_chk("drain", 16'hC000, 8'(8'h91 + i));
            access(16'hC010, 1'b0);
        end
        rd_chk("drain_new", 16'hC000, 8'hD5);
        access(16'hC010, 1'b0);
        rd_chk("drain_last", 16'hC000, 8'h55);

        key_code = 8'h4D;
        key_stb  = 1'b1;
        btns     = 5'b00101;
        cyc();
        key_stb  = 1'b0;
        cyc(); cyc(); cyc();
        rd_chk("btn_status", 16'hC060, 8'h13);
        rd_chk("btn_k0", 16'hC000, 8'hCD);
        access(16'hC010, 1'b0);
        rd_chk("btn_k1", 16'hC000, 8'h95);
        access(16'hC010, 1'b0);
        rd_chk("btn_k2", 16'hC000, 8'h9A);
        access(16'hC010, 1'b0);
        cyc(); cyc();
        rd_chk("btn_held", 16'hC060, 8'h00);
        rd_chk("btn_last", 16'hC000, 8'h1A);
        btns = 5'b0;
        cyc();

        access(16'hC040, 1'b0);
        rd_chk("int_en_status", 16'hC060, 8'h20);
        tick_pulse();
        tick_pulse();
        check_eq("tick2_int", int_req, 1'b0);
        tick_pulse();
        check_eq("tick3_int", int_req, 1'b1);
        rd_chk("int_status", 16'hC060, 8'h60);
        access(16'hC050, 1'b0);
        check_eq("ack_int", int_req, 1'b0);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        check_eq("dis_int", int_req, 1'b0);
        access(16'hC040, 1'b0);
        tick_pulse();
        tick_pulse();
        ab = 16'hC050; acc = 1'b1; read = 1'b0; tick_in = 1'b1;
        cyc();
        acc = 1'b0; tick_in = 1'b0;
        cyc();
        check_eq("ack_wrap_int", int_req, 1'b0);
        tick_pulse();
        tick_pulse();
        ab = 16'hC040; acc = 1'b1; read = 1'b0; tick_in = 1'b1;
        cyc();
        acc = 1'b0; tick_in = 1'b0;
        cyc();
        check_eq("en_wrap_int", int_req, 1'b0);
        rd_chk("en_wrap_status", 16'hC060, 8'h20);
        tick_pulse();
        tick_pulse();
        tick_pulse();
        check_eq("reen_int", int_req, 1'b1);
        access(16'hC050, 1'b0);

        access(16'hC030, 1'b0);
        check_eq("beep1", beep, 1'b1);
        access(16'hC031, 1'b1);
        check_eq("beep0", beep, 1'b0);
        ab = 16'hC020; acc = 1'b1; read = 1'b1;
        #1;
        check_eq("tape_rd_dout", dout, 8'h00);
        check_eq("tape_rd_en", dout_en, 1'b0);
        cyc();
        acc = 1'b0; read = 1'b0;
        check_eq("tape1", tape_out, 1'b1);
        access(16'hC7A5, 1'b0);
        check_eq("vmode", vmode, 8'hA5);

        push_key(8'h33);
        access(16'hC030, 1'b0);
        access(16'hC040, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        check_eq("mid_vmode", vmode, 8'h00);
        check_eq("mid_tape", tape_out, 1'b0);
        check_eq("mid_beep", beep, 1'b0);
        check_eq("mid_int", int_req, 1'b0);
        check_eq("mid_ovf", key_ovf, 1'b0);
        rd_chk("mid_status", 16'hC060, 8'h00);
        rd_chk("mid_key", 16'hC000, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
